// File: rtl/cachepool_dram_burst_splitter_pkg.sv
// Shared types and address helpers for the DRAM burst splitter.
// The scramble moves the channel-select bits up above the channel-local offset.
package cachepool_dram_burst_splitter_pkg;

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  // Address bit boundaries for the default 4-channel, 1 KiB-interleave pool.
  localparam int unsigned DefCb = 10;
  localparam int unsigned DefSb = 2;
  localparam int unsigned DefSo = 28;

  // {a[63:so+sb], a[cb+sb-1:cb], a[so+sb-1:cb+sb], a[cb-1:0]}
  function automatic logic [63:0] scramble_addr(input logic [63:0] addr,
                                                input int unsigned cb,
                                                input int unsigned sb,
                                                input int unsigned so);
    logic [63:0] res;
    res = addr;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= cb && i < so) begin
        res[6'(i)] = addr[6'(i + sb)];
      end else if (i >= so && i < so + sb) begin
        res[6'(i)] = addr[6'(i - so + cb)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cachepool_dram_burst_splitter_if.sv
// AXI read channel (AR + R) used on both sides of the burst splitter.
interface cachepool_dram_burst_splitter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ChanWidth = 2
);
  logic [AddrWidth-1:0] ar_addr;
  logic [7:0]           ar_len;
  logic [IdWidth-1:0]   ar_id;
  logic [ChanWidth-1:0] ar_chan;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [DataWidth-1:0] r_data;
  logic [IdWidth-1:0]   r_id;
  logic [1:0]           r_resp;
  logic                 r_last;
  logic                 r_valid;
  logic                 r_ready;

  modport master (
    output ar_addr, ar_len, ar_id, ar_chan, ar_valid, r_ready,
    input  ar_ready, r_data, r_id, r_resp, r_last, r_valid
  );

  // ar_chan is routing sideband produced by the splitter; upstream ports do not carry it.
  modport slave (
    input  ar_addr, ar_len, ar_id, ar_valid, r_ready,
    output ar_ready, r_data, r_id, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/cachepool_dram_burst_splitter_fifo.sv
// 1-bit flag FIFO holding the "final fragment" marker of each outstanding fragment.
module cachepool_dram_burst_splitter_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = cnt_q == (PtrW + 1)'(Depth);
  assign empty_o = cnt_q == '0;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      end
      cnt_q <= cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/cachepool_dram_burst_splitter.sv
// Splits AR bursts at channel-interleave boundaries into per-channel fragments and
// restores burst framing on R by masking RLAST on all but the final fragment.
module cachepool_dram_burst_splitter
  import cachepool_dram_burst_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 10,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned NumChannels = 4,
  parameter int unsigned ChanBeWidth = 64,
  parameter int unsigned Interleave  = 16,
  parameter int unsigned ChanSize    = 32'h1000_0000,
  parameter int unsigned MaxFrags    = 8,
  parameter bit          ScrambleEn  = 1'b1
) (
  input logic clk_i,
  input logic rst_ni,
  cachepool_dram_burst_splitter_if.slave  slv,
  cachepool_dram_burst_splitter_if.master mst
);
  localparam int unsigned Cb       = $clog2(ChanBeWidth * Interleave);
  localparam int unsigned Sb       = $clog2(NumChannels);
  localparam int unsigned So       = $clog2(ChanSize);
  localparam int unsigned Bo       = $clog2(DataWidth / 8);
  localparam int unsigned BlkBeats = (1 << Cb) >> Bo;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d, scr_addr;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [8:0]           rem_q, rem_d;
  logic [31:0]          blk_left;
  logic [8:0]           frag_beats;
  logic                 is_last, push, pop;
  logic                 fifo_full, fifo_empty, fifo_head;

  // Beats left before the next interleave boundary; rem never exceeds 256, so the
  // truncated blk_left is only selected when it fits.
  assign blk_left   = BlkBeats - 32'(addr_q[Cb-1:Bo]);
  assign frag_beats = (32'(rem_q) < blk_left) ? rem_q : blk_left[8:0];
  assign is_last    = frag_beats == rem_q;
  assign scr_addr   = AddrWidth'(scramble_addr(64'(addr_q), Cb, Sb, So));

  assign slv.ar_ready = state_q == StIdle;
  assign mst.ar_valid = (state_q == StSplit) && !fifo_full;
  assign mst.ar_addr  = ScrambleEn ? scr_addr : addr_q;
  assign mst.ar_len   = 8'(frag_beats - 9'd1);
  assign mst.ar_id    = id_q;
  assign mst.ar_chan  = addr_q[Cb+Sb-1:Cb];
  assign push         = mst.ar_valid & mst.ar_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (slv.ar_valid) begin
          addr_d  = slv.ar_addr;
          id_d    = slv.ar_id;
          rem_d   = 9'(slv.ar_len) + 9'd1;
          state_d = StSplit;
        end
      end
      StSplit: begin
        if (push) begin
          addr_d = addr_q + (AddrWidth'(frag_beats) << Bo);
          rem_d  = rem_q - frag_beats;
          if (is_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
    end
  end

  assign slv.r_valid = mst.r_valid;
  assign slv.r_data  = mst.r_data;
  assign slv.r_id    = mst.r_id;
  assign slv.r_resp  = mst.r_resp;
  assign slv.r_last  = mst.r_last & fifo_head;
  assign mst.r_ready = slv.r_ready;
  assign pop         = mst.r_valid & slv.r_ready & mst.r_last;

  cachepool_dram_burst_splitter_fifo #(
    .Depth (MaxFrags)
  ) u_frag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (is_last),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Every R beat must belong to an issued fragment.
  r_without_fragment: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst.r_valid && slv.r_ready) |-> !fifo_empty);
endmodule

// File: tb/tb_cachepool_dram_burst_splitter.sv
// Directed and randomized bench for the burst splitter: a scrambling and a plain
// instance run in lockstep against a block-arithmetic fragment model.
module tb_cachepool_dram_burst_splitter;
  localparam int unsigned AW = 32, IW = 10, DW = 128, CW = 2;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  chan;
    logic [9:0]  id;
    logic        last;
  } frag_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [9:0]   ar_id, r_id;
  logic         ar_valid, f_ready, r_valid, r_last, r_ready;
  logic [127:0] r_data;
  logic [1:0]   r_resp;

  frag_t exp_q[$];
  frag_t pend_q[$];
  int    n_assert = 0;
  int    n_fail = 0;

  cachepool_dram_burst_splitter_if #(.AddrWidth(AW), .IdWidth(IW), .DataWidth(DW), .ChanWidth(CW))
    s0(), m0(), s1(), m1();

  assign s0.ar_addr = ar_addr;  assign s1.ar_addr = ar_addr;
  assign s0.ar_len = ar_len;    assign s1.ar_len = ar_len;
  assign s0.ar_id = ar_id;      assign s1.ar_id = ar_id;
  assign s0.ar_chan = '0;       assign s1.ar_chan = '0;
  assign s0.ar_valid = ar_valid; assign s1.ar_valid = ar_valid;
  assign s0.r_ready = r_ready;  assign s1.r_ready = r_ready;
  assign m0.ar_ready = f_ready; assign m1.ar_ready = f_ready;
  assign m0.r_data = r_data;    assign m1.r_data = r_data;
  assign m0.r_id = r_id;        assign m1.r_id = r_id;
  assign m0.r_resp = r_resp;    assign m1.r_resp = r_resp;
  assign m0.r_last = r_last;    assign m1.r_last = r_last;
  assign m0.r_valid = r_valid;  assign m1.r_valid = r_valid;

  cachepool_dram_burst_splitter #(.MaxFrags(4), .ScrambleEn(1'b1)) u_dut (
    .clk_i (clk), .rst_ni (rst_n), .slv (s0), .mst (m0)
  );

  cachepool_dram_burst_splitter #(.MaxFrags(4), .ScrambleEn(1'b0)) u_dut_plain (
    .clk_i (clk), .rst_ni (rst_n), .slv (s1), .mst (m1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel index moves to bits [29:28]; the channel-local offset closes the gap.
  function automatic logic [31:0] scr(input logic [31:0] a);
    logic [31:0] ch;
    ch = (a >> 10) & 32'h3;
    return (a & 32'hC000_0000) | (ch << 28) | (((a >> 12) & 32'h3_FFFF) << 10) | (a & 32'h3FF);
  endfunction

  function automatic int n_frags(input logic [31:0] addr, input int len);
    longint a = longint'(addr);
    int rem = len + 1;
    int n = 0;
    while (rem > 0) begin
      int room = int'((1024 - (a % 1024)) / 16);
      int k = (rem < room) ? rem : room;
      a += k * 16;
      rem -= k;
      n++;
    end
    return n;
  endfunction

  function automatic void model_split(input logic [31:0] addr, input int len,
                                      input logic [9:0] id);
    longint a = longint'(addr);
    int rem = len + 1;
    frag_t f;
    while (rem > 0) begin
      int room = int'((1024 - (a % 1024)) / 16);
      int k = (rem < room) ? rem : room;
      f.addr = 32'(a);
      f.len  = 8'(k - 1);
      f.chan = 2'((a / 1024) % 4);
      f.id   = id;
      f.last = (k == rem);
      exp_q.push_back(f);
      a += k * 16;
      rem -= k;
    end
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic send_burst(input logic [31:0] addr, input int len, input logic [9:0] id);
    ar_addr = addr; ar_len = 8'(len); ar_id = id; ar_valid = 1'b1;
    #1 check("ar_ready_idle", s0.ar_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    ar_valid = 1'b0;
    #1 check("ar_ready_split", s0.ar_ready, 1'b0);
    model_split(addr, len, id);
  endtask

  task automatic take_frag(output int waits);
    frag_t e;
    waits = 0;
    f_ready = 1'b1;
    #1;
    while (!m0.ar_valid && waits < 40) begin
      @(negedge clk); waits++; #1;
    end
    check("ar_valid_seen", m0.ar_valid, 1'b1);
    check("frag_expected", exp_q.size() != 0, 1'b1);
    if (!m0.ar_valid || exp_q.size() == 0) begin
      f_ready = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    check("ar_addr_scr", m0.ar_addr, scr(e.addr));
    check("ar_addr_plain", m1.ar_addr, e.addr);
    check("ar_valid_plain", m1.ar_valid, 1'b1);
    check("ar_len", m0.ar_len, e.len);
    check("ar_chan", m0.ar_chan, e.chan);
    check("ar_id", m0.ar_id, e.id);
    @(posedge clk); @(negedge clk);
    f_ready = 1'b0;
    pend_q.push_back(e);
  endtask

  task automatic return_r();
    frag_t f;
    int tries;
    if (pend_q.size() == 0) return;
    f = pend_q.pop_front();
    for (int b = 0; b <= int'(f.len); b++) begin
      r_valid = 1'b1;
      r_data  = {$urandom, $urandom, $urandom, $urandom};
      r_id    = f.id;
      r_resp  = 2'($urandom_range(0, 3));
      r_last  = (b == int'(f.len));
      tries = 0;
      forever begin
        r_ready = (tries >= 2) || ($urandom_range(0, 2) != 0);
        #1;
        check("r_valid", s0.r_valid, 1'b1);
        check("r_last", s0.r_last, f.last && (b == int'(f.len)));
        check("r_last_plain", s1.r_last, f.last && (b == int'(f.len)));
        check("r_data", s0.r_data, r_data);
        check("r_id_resp", {s0.r_id, s0.r_resp}, {f.id, r_resp});
        check("r_ready", m0.r_ready, r_ready);
        @(posedge clk); @(negedge clk);
        if (r_ready) break;
        tries++;
      end
    end
    r_valid = 1'b0; r_last = 1'b0; r_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    ar_addr = '0; ar_len = '0; ar_id = '0; ar_valid = 1'b0; f_ready = 1'b0;
    r_valid = 1'b0; r_last = 1'b1; r_ready = 1'b0; r_data = '0; r_id = '0; r_resp = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ar_ready", s0.ar_ready, 1'b1);
    check("rst_ar_valid", m0.ar_valid, 1'b0);
    check("rst_r_last", s0.r_last, 1'b0);
    r_last = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single fragment within one block
    send_burst(32'h8000_0000, 3, 10'h011);
    take_frag(w);
    check("t1_latency", w, 0);
    return_r();

    // Burst crossing one interleave boundary
    send_burst(32'h8000_03C0, 15, 10'h022);
    take_frag(w); take_frag(w);
    return_r(); return_r();

    // Four full blocks, issued back to back
    send_burst(32'h8000_0000, 255, 10'h033);
    for (int i = 0; i < 4; i++) begin
      take_frag(w);
      check("t3_back_to_back", w, 0);
    end
    repeat (4) return_r();

    // Unaligned start, three fragments
    send_burst(32'h8000_0200, 127, 10'h044);
    repeat (3) take_frag(w);
    repeat (3) return_r();

    // Fragment FIFO fills with R held off
    send_burst(32'h8000_0200, 127, 10'h055);
    repeat (3) take_frag(w);
    send_burst(32'h8000_0000, 191, 10'h066);
    take_frag(w);
    for (int i = 0; i < 3; i++) begin
      check("t4_full_stall", m0.ar_valid, 1'b0);
      @(negedge clk); #1;
    end
    return_r();
    #1 check("t4_reassert", m0.ar_valid, 1'b1);
    take_frag(w);
    #1 check("t4_full_again", m0.ar_valid, 1'b0);
    return_r();
    take_frag(w);
    while (pend_q.size() != 0) return_r();

    // Reset in the middle of a split
    send_burst(32'h8000_0000, 255, 10'h077);
    take_frag(w); take_frag(w);
    r_last = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_ar_ready", s0.ar_ready, 1'b1);
    check("t6_ar_valid", m0.ar_valid, 1'b0);
    check("t6_ar_valid_plain", m1.ar_valid, 1'b0);
    check("t6_r_last", s0.r_last, 1'b0);
    r_last = 1'b0;
    exp_q.delete();
    pend_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send_burst(32'h8000_0000, 3, 10'h088);
    take_frag(w);
    return_r();

    // Randomized bursts of at most four fragments
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      int len, n, tries;
      a = $urandom & 32'h7FFF_FFF0;
      len = $urandom_range(0, 255);
      tries = 0;
      while (n_frags(a, len) > 4 && tries < 50) begin
        len = $urandom_range(0, 255);
        tries++;
      end
      if (n_frags(a, len) > 4) len = 0;
      n = n_frags(a, len);
      send_burst(a, len, 10'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      repeat (n) take_frag(w);
      while (pend_q.size() != 0) return_r();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
